vend_dispense_sequencer: RTL and testbench

Controller that sequences the vending machine's dispense and change hardware. It accumulates coin credit and checks each purchase request against credit and per-slot stock. It then drives timed item-drop pulses, followed by a greedy 20/10/5 change payout. It sits between the coin/keypad front end and the drop actuators, and owns the single shared drop mechanism, so only one drop pulse is active at any time.

---
 rtl/vend_dispense_sequencer.sv | 245 ++++++++++++++++++++++++
 tb/tb_vend_dispense_sequencer.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vend_dispense_sequencer.sv
// Vending dispense sequencer: coin credit, purchase checks, item drops, change payout.
// Define VEND_AUTO_CHANGE_EN to pay leftover credit out automatically after a vend.
module vend_dispense_sequencer #(
  parameter int PULSE_CYC = 2,
  parameter int GAP_CYC   = 3,
  parameter int CREDIT_W  = 8,
  parameter int STOCK_W   = 6
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 coin5,
  input  logic                 coin10,
  input  logic                 coin20,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [1:0]           req_item,
  input  logic [1:0]           req_qty,
  input  logic [CREDIT_W-1:0]  req_price,
  input  logic                 cancel,
  input  logic                 stock_load,
  input  logic [4*STOCK_W-1:0] stock_in,
  output logic [4*STOCK_W-1:0] stock_out,
  output logic [CREDIT_W-1:0]  credit,
  output logic [3:0]           drop_item,
  output logic                 drop5,
  output logic                 drop10,
  output logic                 drop20,
  output logic                 busy,
  output logic                 err_stock,
  output logic                 err_credit
);

  localparam int CNT_MAX = (PULSE_CYC > GAP_CYC) ? PULSE_CYC : GAP_CYC;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int SUM_W   = CREDIT_W + 6;
  localparam int TOT_W   = CREDIT_W + 2;
  localparam logic [CREDIT_W-1:0] CRED_MAX = '1;
`ifdef VEND_AUTO_CHANGE_EN
  localparam bit AUTO_CHG = 1'b1;
`else
  localparam bit AUTO_CHG = 1'b0;
`endif

  typedef enum logic [2:0] {
    IDLE,
    CHECK,
    VEND_PULSE,
    VEND_GAP,
    CHANGE_PULSE,
    CHANGE_GAP
  } state_t;

  state_t              state;
  logic [CNT_W-1:0]    cnt;
  logic [1:0]          rem;
  logic [1:0]          item_q;
  logic [1:0]          qty_q;
  logic [CREDIT_W-1:0] price_q;
  logic [STOCK_W-1:0]  stock [4];

  logic [SUM_W-1:0]    coin_val;
  logic [SUM_W-1:0]    credit_sum;
  logic [CREDIT_W-1:0] credit_in;
  logic [CREDIT_W-1:0] chg_val;
  logic [CREDIT_W-1:0] credit_pay;
  logic [TOT_W-1:0]    total;
  logic [3:0]          item_hot;
  logic                cnt_done;
  logic                sel20;
  logic                sel10;
  logic                sel5;
  logic                pay_start;
  logic                stock_short;
  logic                credit_short;

  // credit_in is the live credit: register plus this cycle's coins, saturated
  always_comb begin
    coin_val = (coin5  ? SUM_W'(5)  : '0)
             + (coin10 ? SUM_W'(10) : '0)
             + (coin20 ? SUM_W'(20) : '0);
    credit_sum = SUM_W'(credit) + coin_val;
    credit_in = (credit_sum > SUM_W'(CRED_MAX)) ?
                CRED_MAX : credit_sum[CREDIT_W-1:0];
    sel20 = credit_in >= CREDIT_W'(20);
    sel10 = !sel20 && (credit_in >= CREDIT_W'(10));
    sel5  = !sel20 && !sel10 && (credit_in >= CREDIT_W'(5));
    chg_val = sel20 ? CREDIT_W'(20) :
              sel10 ? CREDIT_W'(10) :
              sel5  ? CREDIT_W'(5)  : '0;
    credit_pay = credit_in - chg_val;
    total = TOT_W'(qty_q) * TOT_W'(price_q);
    stock_short = {2'b00, stock[item_q]} < (STOCK_W + 2)'(qty_q);
    credit_short = TOT_W'(credit) < total;
    item_hot = 4'b0001 << item_q;
    cnt_done = (cnt == '0);
    pay_start = ((state == IDLE) && !req_valid && cancel &&
                 (credit != '0))
             || ((state == VEND_GAP) && cnt_done && (rem == 2'd1) &&
                 AUTO_CHG && (credit_in != '0))
             || ((state == CHANGE_GAP) && cnt_done &&
                 (credit_in != '0));
  end

  always_comb begin
    stock_out = '0;
    for (int k = 0; k < 4; k++)
      stock_out[k*STOCK_W +: STOCK_W] = stock[k];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      cnt        <= '0;
      rem        <= '0;
      item_q     <= '0;
      qty_q      <= '0;
      price_q    <= '0;
      credit     <= '0;
      for (int k = 0; k < 4; k++)
        stock[k] <= '0;
      req_ready  <= 1'b0;
      busy       <= 1'b0;
      drop_item  <= '0;
      drop5      <= 1'b0;
      drop10     <= 1'b0;
      drop20     <= 1'b0;
      err_stock  <= 1'b0;
      err_credit <= 1'b0;
    end else begin
      credit     <= credit_in;
      err_stock  <= 1'b0;
      err_credit <= 1'b0;
      unique case (state)
        IDLE: begin
          req_ready <= 1'b1;
          busy      <= 1'b0;
          if (req_valid) begin
            item_q    <= req_item;
            qty_q     <= req_qty;
            price_q   <= req_price;
            state     <= CHECK;
            req_ready <= 1'b0;
            busy      <= 1'b1;
          end else if (!(cancel && (credit != '0)) && stock_load) begin
            for (int k = 0; k < 4; k++)
              stock[k] <= stock_in[k*STOCK_W +: STOCK_W];
          end
        end
        CHECK: begin
          if (qty_q == 2'd0) begin
            state     <= IDLE;
            req_ready <= 1'b1;
            busy      <= 1'b0;
          end else if (stock_short) begin
            err_stock <= 1'b1;
            state     <= IDLE;
            req_ready <= 1'b1;
            busy      <= 1'b0;
          end else if (credit_short) begin
            err_credit <= 1'b1;
            state      <= IDLE;
            req_ready  <= 1'b1;
            busy       <= 1'b0;
          end else begin
            credit         <= credit_in - total[CREDIT_W-1:0];
            stock[item_q]  <= stock[item_q] - STOCK_W'(qty_q);
            rem            <= qty_q;
            drop_item      <= item_hot;
            cnt            <= CNT_W'(PULSE_CYC - 1);
            state          <= VEND_PULSE;
          end
        end
        VEND_PULSE: begin
          if (cnt_done) begin
            drop_item <= '0;
            cnt       <= CNT_W'(GAP_CYC - 1);
            state     <= VEND_GAP;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        VEND_GAP: begin
          if (cnt_done) begin
            rem <= rem - 2'd1;
            if (rem != 2'd1) begin
              drop_item <= item_hot;
              cnt       <= CNT_W'(PULSE_CYC - 1);
              state     <= VEND_PULSE;
            end else begin
              state     <= IDLE;
              req_ready <= 1'b1;
              busy      <= 1'b0;
            end
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        CHANGE_PULSE: begin
          if (cnt_done) begin
            drop5  <= 1'b0;
            drop10 <= 1'b0;
            drop20 <= 1'b0;
            cnt    <= CNT_W'(GAP_CYC - 1);
            state  <= CHANGE_GAP;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        CHANGE_GAP: begin
          if (cnt_done) begin
            state     <= IDLE;
            req_ready <= 1'b1;
            busy      <= 1'b0;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        default: begin
          state     <= IDLE;
          req_ready <= 1'b1;
          busy      <= 1'b0;
        end
      endcase
      // Payout entry overrides the plain return to IDLE chosen above
      if (pay_start) begin
        if (sel5 || sel10 || sel20) begin
          credit    <= credit_pay;
          drop5     <= sel5;
          drop10    <= sel10;
          drop20    <= sel20;
          cnt       <= CNT_W'(PULSE_CYC - 1);
          state     <= CHANGE_PULSE;
          req_ready <= 1'b0;
          busy      <= 1'b1;
        end else begin
          credit    <= '0;
          state     <= IDLE;
          req_ready <= 1'b1;
          busy      <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_vend_dispense_sequencer.sv
// Bench for vend_dispense_sequencer: directed steps plus random ops vs a transaction model.
module tb_vend_dispense_sequencer;

  localparam int PULSE = 2;
  localparam int GAP   = 3;
  localparam int CW    = 8;
  localparam int SW    = 6;
`ifdef VEND_AUTO_CHANGE_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          coin5 = 1'b0;
  logic          coin10 = 1'b0;
  logic          coin20 = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [1:0]    req_item = '0;
  logic [1:0]    req_qty = '0;
  logic [CW-1:0] req_price = '0;
  logic          cancel = 1'b0;
  logic          stock_load = 1'b0;
  logic [4*SW-1:0] stock_in = '0;
  logic [4*SW-1:0] stock_out;
  logic [CW-1:0] credit;
  logic [3:0]    drop_item;
  logic          drop5;
  logic          drop10;
  logic          drop20;
  logic          busy;
  logic          err_stock;
  logic          err_credit;

  always #5 clk = ~clk;

  vend_dispense_sequencer #(
    .PULSE_CYC(PULSE), .GAP_CYC(GAP), .CREDIT_W(CW), .STOCK_W(SW)
  ) dut (
    .clk(clk), .reset(reset),
    .coin5(coin5), .coin10(coin10), .coin20(coin20),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_item(req_item), .req_qty(req_qty), .req_price(req_price),
    .cancel(cancel), .stock_load(stock_load),
    .stock_in(stock_in), .stock_out(stock_out),
    .credit(credit), .drop_item(drop_item),
    .drop5(drop5), .drop10(drop10), .drop20(drop20),
    .busy(busy), .err_stock(err_stock), .err_credit(err_credit)
  );

  int nvec = 0;
  int nerr = 0;
  int m_credit = 0;
  int m_stock [4];
  logic [10:0] expq [$];

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [10:0] observed();
    return {busy, req_ready, drop_item, drop20, drop10, drop5,
            err_stock, err_credit};
  endfunction

  function automatic void push(bit b, logic [3:0] it, logic [2:0] cn,
                               bit es, bit ec);
    expq.push_back({b, ~b, it, cn, es, ec});
  endfunction

  function automatic void push_idle(bit es, bit ec);
    push(1'b0, 4'b0, 3'b0, es, ec);
  endfunction

  // one output pulse followed by its gap, all while busy
  function automatic void push_pulse(logic [3:0] it, logic [2:0] cn);
    for (int i = 0; i < PULSE; i++) push(1'b1, it, cn, 1'b0, 1'b0);
    for (int i = 0; i < GAP; i++) push(1'b1, 4'b0, 3'b0, 1'b0, 1'b0);
  endfunction

  function automatic void model_change();
    while (m_credit > 0) begin
      if (m_credit < 5) begin
        m_credit = 0;
      end else if (m_credit >= 20) begin
        m_credit -= 20;
        push_pulse(4'b0, 3'b100);
      end else if (m_credit >= 10) begin
        m_credit -= 10;
        push_pulse(4'b0, 3'b010);
      end else begin
        m_credit -= 5;
        push_pulse(4'b0, 3'b001);
      end
    end
    push_idle(1'b0, 1'b0);
  endfunction

  function automatic void model_purchase(int item, int qty, int price);
    push(1'b1, 4'b0, 3'b0, 1'b0, 1'b0);
    if (qty == 0) begin
      push_idle(1'b0, 1'b0);
    end else if (m_stock[item] < qty) begin
      push_idle(1'b1, 1'b0);
    end else if (m_credit < qty * price) begin
      push_idle(1'b0, 1'b1);
    end else begin
      m_credit -= qty * price;
      m_stock[item] -= qty;
      for (int i = 0; i < qty; i++) push_pulse(4'(1 << item), 3'b0);
      if (AUTO && m_credit > 0) model_change();
      else push_idle(1'b0, 1'b0);
    end
  endfunction

  function automatic logic [4*SW-1:0] pack_stock();
    logic [4*SW-1:0] p;
    p = '0;
    for (int k = 0; k < 4; k++) p[k*SW +: SW] = SW'(m_stock[k]);
    return p;
  endfunction

  // Checks queued samples at successive negedges; optionally drops a coin10
  task automatic run_q(input int inj_idx);
    int n;
    n = expq.size();
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      coin10 = 1'b0;
      chk($sformatf("trace[%0d]", i), 64'(observed()), 64'(expq[i]));
      if (i == inj_idx) coin10 = 1'b1;
    end
    chk("credit", 64'(credit), 64'(m_credit));
    chk("stock", 64'(stock_out), 64'(pack_stock()));
  endtask

  task automatic run_op(input bit rv, input bit cn, input bit sl,
                        input int item, input int qty, input int price,
                        input logic [4*SW-1:0] stk);
    expq.delete();
    if (rv) begin
      model_purchase(item, qty, price);
    end else if (cn && m_credit > 0) begin
      model_change();
    end else begin
      if (sl)
        for (int k = 0; k < 4; k++) m_stock[k] = int'(stk[k*SW +: SW]);
      push_idle(1'b0, 1'b0);
    end
    push_idle(1'b0, 1'b0);
    req_valid = rv;
    cancel = cn;
    stock_load = sl;
    req_item = 2'(item);
    req_qty = 2'(qty);
    req_price = CW'(price);
    stock_in = stk;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    cancel = 1'b0;
    stock_load = 1'b0;
    run_q(-1);
  endtask

  task automatic coins(input bit c5, input bit c10, input bit c20);
    coin5 = c5;
    coin10 = c10;
    coin20 = c20;
    @(posedge clk);
    #1;
    coin5 = 1'b0;
    coin10 = 1'b0;
    coin20 = 1'b0;
    m_credit += (c5 ? 5 : 0) + (c10 ? 10 : 0) + (c20 ? 20 : 0);
    if (m_credit > 255) m_credit = 255;
    @(negedge clk);
    chk("coin_credit", 64'(credit), 64'(m_credit));
  endtask

  function automatic logic [4*SW-1:0] fill(int a, int b, int c, int d);
    return {SW'(d), SW'(c), SW'(b), SW'(a)};
  endfunction

  initial begin
    logic [4*SW-1:0] stk;
    int kind;
    for (int k = 0; k < 4; k++) m_stock[k] = 0;

    // reset held with busy inputs
    for (int i = 0; i < 4; i++) begin
      coin20 = 1'(i & 1);
      req_valid = 1'(~i & 1);
      req_qty = 2'd1;
      @(negedge clk);
      chk("reset_outs", {req_ready, busy, drop_item, drop5, drop10, drop20,
                         err_stock, err_credit, credit, stock_out}, 64'd0);
    end
    coin20 = 1'b0;
    req_valid = 1'b0;
    req_qty = 2'd0;
    reset = 1'b1;
    @(negedge clk);
    chk("ready_after_reset", 64'(req_ready), 64'd1);
    chk("credit_after_reset", 64'(credit), 64'd0);

    // basic purchase with change
    run_op(0, 0, 1, 0, 0, 0, fill(10, 10, 10, 10));
    coins(0, 0, 1);
    run_op(1, 0, 0, 1, 1, 15, '0);
    run_op(0, 1, 0, 0, 0, 0, '0);

    // insufficient credit, then clear it
    coins(0, 1, 0);
    run_op(1, 0, 0, 0, 1, 15, '0);
    run_op(0, 1, 0, 0, 0, 0, '0);

    // insufficient stock, alone and together with insufficient credit
    run_op(0, 0, 1, 0, 0, 0, fill(10, 10, 10, 1));
    coins(0, 0, 1);
    coins(0, 0, 1);
    run_op(1, 0, 0, 3, 2, 5, '0);
    run_op(1, 0, 0, 3, 2, 100, '0);
    run_op(0, 1, 0, 0, 0, 0, '0);

    // simultaneous coins then greedy refund
    coins(1, 1, 1);
    run_op(0, 1, 0, 0, 0, 0, '0);

    // saturation then long refund
    for (int i = 0; i < 12; i++) coins(0, 0, 1);
    coins(0, 1, 0);
    coins(0, 0, 1);
    run_op(0, 1, 0, 0, 0, 0, '0);

    // two-item vend
    coins(0, 1, 1);
    run_op(1, 0, 0, 0, 2, 10, '0);
    run_op(0, 1, 0, 0, 0, 0, '0);

    // qty 0, full-width total, odd remainder forfeited on refund
    coins(0, 0, 1);
    run_op(1, 0, 0, 2, 0, 5, '0);
    run_op(1, 0, 0, 2, 3, 255, '0);
    run_op(1, 0, 0, 2, 1, 17, '0);
    run_op(0, 1, 1, 0, 0, 0, fill(1, 1, 1, 1));
    run_op(0, 1, 1, 0, 0, 0, fill(4, 5, 6, 7));

    // coin arriving during payout is refunded too
    coins(1, 0, 0);
    expq.delete();
    push_pulse(4'b0, 3'b001);
    push_pulse(4'b0, 3'b010);
    push_idle(1'b0, 1'b0);
    push_idle(1'b0, 1'b0);
    m_credit = 0;
    cancel = 1'b1;
    @(posedge clk);
    #1;
    cancel = 1'b0;
    run_q(2);

    // random operations
    for (int it = 0; it < 60; it++) begin
      for (int c = 0; c < int'($urandom_range(0, 2)); c++)
        coins(1'($urandom), 1'($urandom), 1'($urandom));
      kind = int'($urandom_range(0, 9));
      for (int k = 0; k < 4; k++) stk[k*SW +: SW] = SW'($urandom_range(0, 5));
      run_op(kind < 6, (kind >= 6) || ($urandom_range(0, 3) == 0),
             (kind >= 8) || ($urandom_range(0, 3) == 0),
             int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
             ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 255))
                                         : int'($urandom_range(0, 30)),
             stk);
    end

    // asynchronous reset in the middle of a vend
    run_op(0, 0, 1, 0, 0, 0, fill(9, 9, 9, 9));
    coins(0, 0, 1);
    req_valid = 1'b1;
    req_item = 2'd2;
    req_qty = 2'd3;
    req_price = CW'(5);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    chk("midvend_reset", {req_ready, busy, drop_item, drop5, drop10, drop20,
                          err_stock, err_credit, credit, stock_out}, 64'd0);
    @(negedge clk);
    reset = 1'b1;
    m_credit = 0;
    for (int k = 0; k < 4; k++) m_stock[k] = 0;
    @(negedge clk);
    chk("ready_after_midreset", 64'(req_ready), 64'd1);
    run_op(0, 1, 0, 0, 0, 0, '0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
